// File: rtl/fpu_divsqrt_iter.sv
// fpu_divsqrt_iter: iterative floating-point divide / square root, one result bit per clock.
// Restoring division and a restoring digit-by-digit root share one remainder/quotient datapath.
// Optional feature: define FPU_DIVSQRT_RNE_EN for round-to-nearest-even and overflow to infinity.
// Without it the unit truncates toward zero and saturates an overflow to the largest finite value.
module fpu_divsqrt_iter #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   op,
    input  logic [EXP_W+MAN_W:0]   rs1,
    input  logic [EXP_W+MAN_W:0]   rs2,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   fpu_result,
    output logic [4:0]             fpu_flags
);

    localparam int unsigned W       = 1 + EXP_W + MAN_W;
    localparam int unsigned Q       = MAN_W + 2;
    localparam int unsigned CNT_W   = $clog2(MAN_W + 3);
    localparam int unsigned EW      = EXP_W + 2;
    localparam int unsigned RW      = Q + 3;
    localparam int unsigned MW1     = MAN_W + 1;
    localparam int unsigned BIAS    = (1 << (EXP_W - 1)) - 1;
    localparam int unsigned EXP_MAX = (1 << EXP_W) - 1;

    localparam logic signed [EW-1:0] EXP_ONE  = EW'(1);
    localparam logic signed [EW-1:0] EXP_ZERO = EW'(0);
    localparam logic signed [EW-1:0] EXP_BIAS = EW'(BIAS);
    localparam logic signed [EW-1:0] EXP_OVF  = EW'(EXP_MAX);

    localparam logic [4:0] FL_NV = 5'b10000;
    localparam logic [4:0] FL_DZ = 5'b01000;
    localparam logic [4:0] FL_OF = 5'b00100;
    localparam logic [4:0] FL_UF = 5'b00010;
    localparam logic [4:0] FL_NX = 5'b00001;

    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        NORM,
        DONE
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   op_q, op_d;
    logic                   sign_q, sign_d;
    logic signed [EW-1:0]   exp_q, exp_d;
    logic [MAN_W:0]         div_b_q, div_b_d;
    logic [RW-1:0]          rem_q, rem_d;
    logic [Q-1:0]           quo_q, quo_d;
    logic [2*Q-1:0]         rad_q, rad_d;
    logic                   out_valid_q, out_valid_d;
    logic [W-1:0]           res_q, res_d;
    logic [4:0]             flags_q, flags_d;

    // Operand field decode
    logic                   s1, s2;
    logic [EXP_W-1:0]       e1, e2;
    logic [MAN_W-1:0]       m1, m2;
    logic                   z1, z2, inf1, inf2, nan1, nan2, snan1, snan2;

    assign s1    = rs1[W-1];
    assign s2    = rs2[W-1];
    assign e1    = rs1[W-2 -: EXP_W];
    assign e2    = rs2[W-2 -: EXP_W];
    assign m1    = rs1[MAN_W-1:0];
    assign m2    = rs2[MAN_W-1:0];
    assign z1    = (e1 == '0);
    assign z2    = (e2 == '0);
    assign inf1  = (e1 == '1) && (m1 == '0);
    assign inf2  = (e2 == '1) && (m2 == '0);
    assign nan1  = (e1 == '1) && (m1 != '0);
    assign nan2  = (e2 == '1) && (m2 != '0);
    assign snan1 = nan1 && !m1[MAN_W-1];
    assign snan2 = nan2 && !m2[MAN_W-1];

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = out_valid_q;
    assign fpu_result = res_q;
    assign fpu_flags  = flags_q;

    // Special-operand detection and result, resolved in priority order at accept
    logic                   spec_hit;
    logic [W-1:0]           spec_res;
    logic [4:0]             spec_flags;
    logic                   sx;

    always_comb begin
        spec_hit   = 1'b0;
        spec_res   = '0;
        spec_flags = '0;
        sx         = s1 ^ s2;
        if (!op) begin
            if (nan1 || nan2) begin
                spec_hit   = 1'b1;
                spec_res   = QNAN;
                spec_flags = (snan1 || snan2) ? FL_NV : 5'b0;
            end else if ((z1 && z2) || (inf1 && inf2)) begin
                spec_hit   = 1'b1;
                spec_res   = QNAN;
                spec_flags = FL_NV;
            end else if (z2) begin
                spec_hit   = 1'b1;
                spec_res   = {sx, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                spec_flags = FL_DZ;
            end else if (inf1) begin
                spec_hit   = 1'b1;
                spec_res   = {sx, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            end else if (inf2 || z1) begin
                spec_hit   = 1'b1;
                spec_res   = {sx, {(W-1){1'b0}}};
            end
        end else begin
            if (nan1) begin
                spec_hit   = 1'b1;
                spec_res   = QNAN;
                spec_flags = snan1 ? FL_NV : 5'b0;
            end else if (z1) begin
                spec_hit   = 1'b1;
                spec_res   = {s1, {(W-1){1'b0}}};
            end else if (s1) begin
                spec_hit   = 1'b1;
                spec_res   = QNAN;
                spec_flags = FL_NV;
            end else if (inf1) begin
                spec_hit   = 1'b1;
                spec_res   = {1'b0, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            end
        end
    end

    // Initial exponent and radicand for the normal path
    logic signed [EW-1:0]   div_exp, e_unb, sqrt_exp;
    logic [MAN_W+1:0]       rad_top;

    always_comb begin
        div_exp  = $signed({2'b00, e1}) - $signed({2'b00, e2}) + EXP_BIAS;
        e_unb    = $signed({2'b00, e1}) - EXP_BIAS;
        sqrt_exp = (e_unb >>> 1) + EXP_BIAS;
        rad_top  = e_unb[0] ? {1'b1, m1, 1'b0} : {1'b0, 1'b1, m1};
    end

    // Normalise, round and range-check the finished quotient or root
    logic [MAN_W-1:0]       mant, mant_f;
    logic                   guard, sticky, carry;
    logic signed [EW-1:0]   exp_n, exp_f;
    logic [W-1:0]           ovf_res, norm_res;
    logic [4:0]             norm_flags;
`ifdef FPU_DIVSQRT_RNE_EN
    logic                   round_up;
    logic [MAN_W:0]         mant_r;
`endif

    always_comb begin
        mant       = '0;
        mant_f     = '0;
        guard      = 1'b0;
        sticky     = 1'b0;
        carry      = 1'b0;
        exp_n      = exp_q;
        exp_f      = '0;
        ovf_res    = '0;
        norm_res   = '0;
        norm_flags = '0;
`ifdef FPU_DIVSQRT_RNE_EN
        round_up   = 1'b0;
        mant_r     = '0;
`endif
        if (quo_q[Q-1]) begin
            mant   = quo_q[Q-2:1];
            guard  = quo_q[0];
            sticky = (rem_q != '0);
        end else begin
            // Quotient below 1: the guard bit comes from the doubled remainder.
            mant   = quo_q[Q-3:0];
            guard  = (rem_q >= RW'(div_b_q));
            sticky = ((guard ? (rem_q - RW'(div_b_q)) : rem_q) != '0);
            exp_n  = exp_q - EXP_ONE;
        end
`ifdef FPU_DIVSQRT_RNE_EN
        round_up = guard & (sticky | mant[0]);
        mant_r   = {1'b0, mant} + MW1'(round_up);
        carry    = mant_r[MAN_W];
        mant_f   = mant_r[MAN_W-1:0];
        ovf_res  = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
`else
        carry    = 1'b0;
        mant_f   = mant;
        ovf_res  = {sign_q, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
`endif
        exp_f = exp_n + (carry ? EXP_ONE : EXP_ZERO);
        if (exp_f >= EXP_OVF) begin
            norm_res   = ovf_res;
            norm_flags = FL_OF | FL_NX;
        end else if (exp_f <= EXP_ZERO) begin
            norm_res   = {sign_q, {(W-1){1'b0}}};
            norm_flags = FL_UF | FL_NX;
        end else begin
            norm_res   = {sign_q, exp_f[EXP_W-1:0], mant_f};
            norm_flags = (guard | sticky) ? FL_NX : 5'b0;
        end
    end

    // Next-state, iteration step and output register updates
    logic                   ge;
    logic [RW-1:0]          rem_sh, trial;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        sign_d      = sign_q;
        exp_d       = exp_q;
        div_b_d     = div_b_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        rad_d       = rad_q;
        out_valid_d = out_valid_q;
        res_d       = res_q;
        flags_d     = flags_q;
        ge          = 1'b0;
        rem_sh      = '0;
        trial       = '0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d   = op;
                    sign_d = op ? s1 : (s1 ^ s2);
                    if (spec_hit) begin
                        res_d       = spec_res;
                        flags_d     = spec_flags;
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        cnt_d   = '0;
                        quo_d   = '0;
                        state_d = CALC;
                        if (!op) begin
                            exp_d   = div_exp;
                            rem_d   = RW'({1'b1, m1});
                            div_b_d = {1'b1, m2};
                            rad_d   = '0;
                        end else begin
                            exp_d   = sqrt_exp;
                            rem_d   = '0;
                            rad_d   = {rad_top, {(MAN_W+2){1'b0}}};
                        end
                    end
                end
            end
            CALC: begin
                if (!op_q) begin
                    ge    = (rem_q >= RW'(div_b_q));
                    rem_d = ge ? ((rem_q - RW'(div_b_q)) << 1) : (rem_q << 1);
                end else begin
                    rem_sh = {rem_q[RW-3:0], rad_q[2*Q-1 -: 2]};
                    trial  = RW'({quo_q, 2'b01});
                    ge     = (rem_sh >= trial);
                    rem_d  = ge ? (rem_sh - trial) : rem_sh;
                    rad_d  = {rad_q[2*Q-3:0], 2'b00};
                end
                quo_d = {quo_q[Q-2:0], ge};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(Q - 1)) begin
                    state_d = NORM;
                end
            end
            NORM: begin
                res_d       = norm_res;
                flags_d     = norm_flags;
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            op_q        <= 1'b0;
            sign_q      <= 1'b0;
            exp_q       <= '0;
            div_b_q     <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            rad_q       <= '0;
            out_valid_q <= 1'b0;
            res_q       <= '0;
            flags_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            sign_q      <= sign_d;
            exp_q       <= exp_d;
            div_b_q     <= div_b_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            rad_q       <= rad_d;
            out_valid_q <= out_valid_d;
            res_q       <= res_d;
            flags_q     <= flags_d;
        end
    end

endmodule

// File: tb/tb_fpu_divsqrt_iter.sv
// Bench for fpu_divsqrt_iter (binary32): directed test-plan cases, handshake/reset
// behaviour, then random operands against an integer-arithmetic reference model.
module tb_fpu_divsqrt_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        op;
    logic [31:0] rs1, rs2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] fpu_result;
    logic [4:0]  fpu_flags;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] QNAN = 32'h7FC00000;
    localparam int          LAT  = 27;
`ifdef FPU_DIVSQRT_RNE_EN
    localparam logic [31:0] THIRD   = 32'h3EAAAAAB;
    localparam logic [31:0] OVF_RES = 32'h7F800000;
`else
    localparam logic [31:0] THIRD   = 32'h3EAAAAAA;
    localparam logic [31:0] OVF_RES = 32'h7F7FFFFF;
`endif

    always #5 clk = ~clk;

    fpu_divsqrt_iter dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .rs1        (rs1),
        .rs2        (rs2),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fpu_result (fpu_result),
        .fpu_flags  (fpu_flags)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference: returns {special, flags[4:0], result[31:0]}
    function automatic logic [37:0] model(input logic o, input logic [31:0] a, input logic [31:0] b);
        logic sa, sb, sx, za, zb, ia, ib, na, nb, sna, snb, guard, sticky;
        int ea, eb, e, odd, drop;
        longint unsigned ma, mb, num, q, r, m24, dropped, rr, lo, hi, mid, rt;
        sa  = a[31];
        sb  = b[31];
        sx  = o ? sa : (sa ^ sb);
        ea  = int'(a[30:23]);
        eb  = int'(b[30:23]);
        za  = (ea == 0);
        zb  = (eb == 0);
        ia  = (ea == 255) && (a[22:0] == 23'h0);
        ib  = (eb == 255) && (b[22:0] == 23'h0);
        na  = (ea == 255) && (a[22:0] != 23'h0);
        nb  = (eb == 255) && (b[22:0] != 23'h0);
        sna = na && !a[22];
        snb = nb && !b[22];
        ma  = 64'h800000 | 64'(a[22:0]);
        mb  = 64'h800000 | 64'(b[22:0]);
        if (!o) begin
            if (na || nb) return {1'b1, (sna || snb) ? 5'h10 : 5'h00, QNAN};
            if ((za && zb) || (ia && ib)) return {1'b1, 5'h10, QNAN};
            if (zb) return {1'b1, 5'h08, {sx, 8'hFF, 23'h0}};
            if (ia) return {1'b1, 5'h00, {sx, 8'hFF, 23'h0}};
            if (ib || za) return {1'b1, 5'h00, {sx, 31'h0}};
            num = ma << 26;
            q   = num / mb;
            r   = num % mb;
            if (q >= (64'd1 << 26)) begin
                e    = ea - eb + 127;
                drop = 3;
            end else begin
                e    = ea - eb + 126;
                drop = 2;
            end
            m24     = q >> drop;
            dropped = q & ((64'd1 << drop) - 64'd1);
            guard   = ((dropped >> (drop - 1)) & 64'd1) != 64'd0;
            sticky  = ((dropped & ((64'd1 << (drop - 1)) - 64'd1)) != 64'd0) || (r != 64'd0);
        end else begin
            if (na) return {1'b1, sna ? 5'h10 : 5'h00, QNAN};
            if (za) return {1'b1, 5'h00, {sa, 31'h0}};
            if (sa) return {1'b1, 5'h10, QNAN};
            if (ia) return {1'b1, 5'h00, 32'h7F800000};
            e   = ea - 127;
            odd = e & 1;
            e   = (e - odd) / 2 + 127;
            rr  = (ma << odd) << 25;
            lo  = 64'd0;
            hi  = 64'd1 << 26;
            while (hi - lo > 64'd1) begin
                mid = (lo + hi) / 64'd2;
                if (mid * mid <= rr) lo = mid;
                else hi = mid;
            end
            rt     = lo;
            m24    = rt >> 1;
            guard  = (rt & 64'd1) != 64'd0;
            sticky = (rr - rt * rt) != 64'd0;
        end
`ifdef FPU_DIVSQRT_RNE_EN
        if (guard && (sticky || ((m24 & 64'd1) != 64'd0))) m24 = m24 + 64'd1;
        if (m24 == (64'd1 << 24)) begin
            m24 = 64'd1 << 23;
            e   = e + 1;
        end
`endif
        if (e >= 255) begin
`ifdef FPU_DIVSQRT_RNE_EN
            return {1'b0, 5'h05, {sx, 8'hFF, 23'h0}};
`else
            return {1'b0, 5'h05, {sx, 8'hFE, 23'h7FFFFF}};
`endif
        end
        if (e <= 0) return {1'b0, 5'h03, {sx, 31'h0}};
        return {1'b0, {4'h0, guard || sticky}, {sx, 8'(e), 23'(m24)}};
    endfunction

    function automatic logic [31:0] rand_operand();
        int unsigned k;
        logic [31:0] v;
        k = $urandom_range(0, 19);
        v = $urandom;
        case (k)
            0:       v = {v[31], 31'h0};
            1:       v = {v[31], 8'hFF, 23'h0};
            2:       v = {v[31], 8'hFF, v[22], (v[21:0] == 22'h0) ? 22'h1 : v[21:0]};
            3:       v = {v[31], 8'h00, v[22:0]};
            default: v = {v[31], 8'($urandom_range(1, 254)), v[22:0]};
        endcase
        return v;
    endfunction

    // Issue one request with out_ready high and check latency, result and flags
    task automatic run_op(input string tag, input logic o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input logic [4:0] exp_fl, input int exp_lat);
        int lat;
        @(negedge clk);
        check({tag, " in_ready"}, 64'(in_ready), 64'(1));
        in_valid = 1'b1;
        op       = o;
        rs1      = a;
        rs2      = b;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat      = 1;
        while (!out_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " result"}, 64'(fpu_result), 64'(exp_res));
        check({tag, " flags"}, 64'(fpu_flags), 64'(exp_fl));
    endtask

    initial begin
        logic [37:0] m;
        logic        o;
        logic [31:0] a, b;
        int          lat;

        rst       = 1'b1;
        in_valid  = 1'b0;
        op        = 1'b0;
        rs1       = '0;
        rs2       = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset out_valid", 64'(out_valid), 64'(0));
        check("reset result", 64'(fpu_result), 64'(0));
        check("reset flags", 64'(fpu_flags), 64'(0));
        check("reset in_ready", 64'(in_ready), 64'(1));
        rst = 1'b0;

        run_op("div 6/3", 1'b0, 32'h40C00000, 32'h40400000, 32'h40000000, 5'h00, LAT);
        run_op("div 1/3", 1'b0, 32'h3F800000, 32'h40400000, THIRD, 5'h01, LAT);
        run_op("sqrt 25", 1'b1, 32'h41C80000, 32'h0, 32'h40A00000, 5'h00, LAT);
        run_op("sqrt 2", 1'b1, 32'h40000000, 32'h0, 32'h3FB504F3, 5'h01, LAT);
        run_op("div by zero", 1'b0, 32'h3F800000, 32'h00000000, 32'h7F800000, 5'h08, 1);
        run_op("sqrt neg", 1'b1, 32'hC0800000, 32'h0, QNAN, 5'h10, 1);
        run_op("overflow", 1'b0, 32'h7F7FFFFF, 32'h00800000, OVF_RES, 5'h05, LAT);
        run_op("underflow", 1'b0, 32'h00800000, 32'h7F000000, 32'h00000000, 5'h03, LAT);
        run_op("snan div", 1'b0, 32'h7F800001, 32'h3F800000, QNAN, 5'h10, 1);
        run_op("qnan div", 1'b0, 32'h3F800000, 32'hFFC00123, QNAN, 5'h00, 1);
        run_op("inf/inf", 1'b0, 32'hFF800000, 32'h7F800000, QNAN, 5'h10, 1);
        run_op("0/0", 1'b0, 32'h80000000, 32'h00000000, QNAN, 5'h10, 1);
        run_op("inf/x", 1'b0, 32'h7F800000, 32'hC0000000, 32'hFF800000, 5'h00, 1);
        run_op("x/inf", 1'b0, 32'hC0000000, 32'hFF800000, 32'h00000000, 5'h00, 1);
        run_op("subnormal/x", 1'b0, 32'h00000001, 32'hBF800000, 32'h80000000, 5'h00, 1);
        run_op("sqrt -0", 1'b1, 32'h80000000, 32'h0, 32'h80000000, 5'h00, 1);
        run_op("sqrt +inf", 1'b1, 32'h7F800000, 32'h0, 32'h7F800000, 5'h00, 1);
        run_op("sqrt -inf", 1'b1, 32'hFF800000, 32'h0, QNAN, 5'h10, 1);
        run_op("sqrt snan", 1'b1, 32'h7FA00000, 32'h0, QNAN, 5'h10, 1);

        // Backpressure: result held while out_ready low, new requests ignored
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        op        = 1'b0;
        rs1       = 32'h40C00000;
        rs2       = 32'h40400000;
        @(posedge clk);
        @(negedge clk);
        rs1 = 32'h3F800000;
        lat = 1;
        while (!out_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        check("bp latency", 64'(lat), 64'(LAT));
        for (int i = 0; i < 10; i++) begin
            check("bp out_valid", 64'(out_valid), 64'(1));
            check("bp result", 64'(fpu_result), 64'(32'h40000000));
            check("bp flags", 64'(fpu_flags), 64'(0));
            check("bp in_ready", 64'(in_ready), 64'(0));
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp release out_valid", 64'(out_valid), 64'(0));
        check("bp release in_ready", 64'(in_ready), 64'(1));
        @(negedge clk);
        check("bp not queued", 64'(out_valid), 64'(0));
        check("bp idle in_ready", 64'(in_ready), 64'(1));

        // Reset in the middle of a divide
        run_op("pre-reset sqrt 2", 1'b1, 32'h40000000, 32'h0, 32'h3FB504F3, 5'h01, LAT);
        @(negedge clk);
        in_valid = 1'b1;
        op       = 1'b0;
        rs1      = 32'h3F800000;
        rs2      = 32'h40400000;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        check("mid busy", 64'(in_ready), 64'(0));
        rst = 1'b1;
        #1;
        check("abort out_valid", 64'(out_valid), 64'(0));
        check("abort result", 64'(fpu_result), 64'(0));
        check("abort flags", 64'(fpu_flags), 64'(0));
        check("abort in_ready", 64'(in_ready), 64'(1));
        @(negedge clk);
        rst = 1'b0;
        run_op("post-reset 6/3", 1'b0, 32'h40C00000, 32'h40400000, 32'h40000000, 5'h00, LAT);

        // Random operands against the reference model
        for (int i = 0; i < 150; i++) begin
            o = 1'($urandom_range(0, 1));
            a = rand_operand();
            b = rand_operand();
            m = model(o, a, b);
            run_op(o ? "rand sqrt" : "rand div", o, a, b, m[31:0], m[36:32], m[37] ? 1 : LAT);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
